// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler
// Frame-level sequencer for the 1-D row convolution engine. It pulls one
// 32-pixel row at a time from upstream, holds it for the engine, and fires a
// start pulse. When the engine reports done, it captures the 30 results and
// offers them downstream. A watchdog aborts the frame if the engine hangs.
module conv_row_scheduler #(
    parameter int NUM_ROWS       = 32,
    parameter int TIMEOUT_CYCLES = 128,
    parameter int IDX_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             err_timeout,
    input  logic             row_in_valid,
    output logic             row_in_ready,
    input  logic [255:0]     row_in_data,
    output logic             eng_start,
    output logic [255:0]     eng_row_data,
    input  logic             eng_done,
    input  logic [539:0]     eng_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [539:0]     res_data,
    output logic [IDX_W-1:0] res_row_idx,
    output logic             res_last
);

    // The counter runs from the start pulse and must be able to reach TIMEOUT_CYCLES.
    localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_KICK,
        S_WAIT_ENG,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDX_W-1:0] r_row_idx;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_err_timeout;
    logic             r_row_in_ready;
    logic             r_eng_start;
    logic             r_res_valid;
    logic             r_frame_done;
    logic [255:0]     r_eng_row_data;
    logic [539:0]     r_res_data;

    logic             w_frame_accept;
    logic             w_row_hs;
    logic             w_res_hs;
    logic             w_eng_capture;
    logic             w_timeout;
    logic             w_last_row;

    // frame_start only counts in IDLE; eng_done only counts in WAIT_ENG.
    assign w_frame_accept = (r_state == S_IDLE) && frame_start;
    assign w_row_hs       = (r_state == S_FETCH) && row_in_valid && r_row_in_ready;
    assign w_res_hs       = r_res_valid && res_ready;
    assign w_eng_capture  = (r_state == S_WAIT_ENG) && eng_done;
    // A done pulse in the last allowed cycle beats the watchdog.
    assign w_timeout      = (r_state == S_WAIT_ENG) && !eng_done && (r_wd_cnt == TO_LAST);
    assign w_last_row     = (r_row_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on paths that do not change state.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_frame_accept) w_state_next = S_FETCH;
            S_FETCH:    if (w_row_hs)       w_state_next = S_KICK;
            S_KICK:                         w_state_next = S_WAIT_ENG;
            S_WAIT_ENG: begin
                if (w_eng_capture)          w_state_next = S_OUT;
                else if (w_timeout)         w_state_next = S_IDLE;
            end
            S_OUT: begin
                if (w_res_hs)               w_state_next = w_last_row ? S_IDLE : S_FETCH;
            end
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // Handshake and pulse outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_in_ready <= 1'b0;
            r_eng_start    <= 1'b0;
            r_res_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_row_in_ready <= (w_state_next == S_FETCH);
            r_eng_start    <= (w_state_next == S_KICK);
            r_res_valid    <= (w_state_next == S_OUT);
            r_frame_done   <= w_res_hs && w_last_row;
        end
    end

    // Sticky watchdog flag, cleared only when a new frame is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_timeout <= 1'b0;
        end else if (w_frame_accept) begin
            r_err_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
        end
    end

    // Row index and watchdog counter; the counter restarts as the row is taken,
    // so its value equals the number of cycles elapsed since the start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_idx <= '0;
            r_wd_cnt  <= '0;
        end else begin
            if (w_frame_accept) begin
                r_row_idx <= '0;
            end else if (w_res_hs && !w_last_row) begin
                r_row_idx <= r_row_idx + 1'b1;
            end

            if (w_row_hs) begin
                r_wd_cnt <= '0;
            end else if ((r_state == S_KICK) || (r_state == S_WAIT_ENG)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    // Row and result holding registers; the engine reads the row serially, so it
    // only changes on a row handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these wide data registers are reset on purpose so every
            // output reads zero after reset, not just the control flags.
            r_eng_row_data <= '0;
            r_res_data     <= '0;
        end else begin
            if (w_row_hs) begin
                r_eng_row_data <= row_in_data;
            end
            if (w_eng_capture) begin
                r_res_data <= eng_result;
            end
        end
    end

    assign frame_busy   = (r_state != S_IDLE);
    assign frame_done   = r_frame_done;
    assign err_timeout  = r_err_timeout;
    assign row_in_ready = r_row_in_ready;
    assign eng_start    = r_eng_start;
    assign eng_row_data = r_eng_row_data;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_row_idx  = r_row_idx;
    assign res_last     = r_res_valid && w_last_row;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler
// Directed bench for conv_row_scheduler with a small [-1,2,-1] engine model.
`timescale 1ns/1ps
module tb_conv_row_scheduler;

    localparam int NUM_ROWS       = 4;
    localparam int TIMEOUT_CYCLES = 128;
    localparam int IDX_W          = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             frame_busy;
    logic             frame_done;
    logic             err_timeout;
    logic             row_in_valid;
    logic             row_in_ready;
    logic [255:0]     row_in_data;
    logic             eng_start;
    logic [255:0]     eng_row_data;
    logic             eng_done;
    logic [539:0]     eng_result;
    logic             res_valid;
    logic             res_ready;
    logic [539:0]     res_data;
    logic [IDX_W-1:0] res_row_idx;
    logic             res_last;

    // Engine model pulse and stray pulses injected by the stimulus are ORed.
    logic m_done;
    logic stray_done;
    assign eng_done = m_done | stray_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    // Engine model controls and counters.
    int eng_delay = 66;
    bit eng_hang  = 1'b0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int moved_cnt = 0;

    // Per-frame log filled by run_frame.
    logic [IDX_W-1:0] log_idx[$];
    logic             log_last[$];
    logic [539:0]     log_data[$];
    int               log_done;
    int               log_starts;
    int               hold_cycles;
    bit               stall_start_bad;
    bit               hold_bad;
    logic             busy_at_done;
    logic             err_after_start;

    logic [255:0]     ramp_row;
    logic [255:0]     alt_row;
    logic [539:0]     exp_alt;

    conv_row_scheduler #(
        .NUM_ROWS       (NUM_ROWS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .IDX_W          (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .row_in_valid (row_in_valid),
        .row_in_ready (row_in_ready),
        .row_in_data  (row_in_data),
        .eng_start    (eng_start),
        .eng_row_data (eng_row_data),
        .eng_done     (eng_done),
        .eng_result   (eng_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_row_idx  (res_row_idx),
        .res_last     (res_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "bench did not terminate");
    end

    // Result i = -p[i] + 2*p[i+1] - p[i+2], wrapped to 18 bits.
    function automatic logic [539:0] kernel(input logic [255:0] row);
        logic [539:0] r;
        int a, b, c;
        r = '0;
        for (int i = 0; i < 30; i++) begin
            a = int'($signed(row[8*i +: 8]));
            b = int'($signed(row[8*(i+1) +: 8]));
            c = int'($signed(row[8*(i+2) +: 8]));
            r[18*i +: 18] = 18'(2*b - a - c);
        end
        return r;
    endfunction

    // Engine model: sees eng_start, waits eng_delay cycles, pulses done for one cycle.
    initial begin : eng_model
        logic [255:0] snap;
        m_done     = 1'b0;
        eng_result = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                start_cnt++;
                snap = eng_row_data;
                if (!eng_hang) begin
                    repeat (eng_delay) begin
                        @(negedge clk);
                        if (eng_row_data !== snap) moved_cnt++;
                    end
                    eng_result = kernel(eng_row_data);
                    m_done     = 1'b1;
                    done_cnt++;
                    @(negedge clk);
                    m_done = 1'b0;
                end
            end
        end
    end

    // Runs one frame: upstream stall before row 1, backpressure on result 2,
    // optional junk (frame_start + stray eng_done) during the stall.
    task automatic run_frame(input logic [255:0] row, input int up_stall, input int dn_stall,
                             input bit junk);
        int               rows_sent, up_left, dn_left, s0, cyc;
        bit               held_set, junk_done;
        logic [539:0]     held_data;
        logic [IDX_W-1:0] held_idx;
        log_idx.delete(); log_last.delete(); log_data.delete();
        log_done = 0; hold_cycles = 0; stall_start_bad = 0; hold_bad = 0; busy_at_done = 1'b1;
        rows_sent = 0; up_left = up_stall; dn_left = dn_stall; held_set = 0; junk_done = 0;
        held_data = '0; held_idx = '0;
        s0 = start_cnt;
        @(negedge clk);
        frame_start = 1'b1; row_in_data = row; row_in_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        err_after_start = err_timeout;
        cyc = 0;
        while (log_done == 0 && cyc < 3000) begin
            row_in_valid = (rows_sent < NUM_ROWS);
            if (rows_sent == 1 && row_in_ready && up_left > 0) begin
                row_in_valid = 1'b0;
                up_left--;
                if (eng_start) stall_start_bad = 1;
                if (junk && !junk_done) begin
                    frame_start = 1'b1;
                    stray_done  = 1'b1;
                    junk_done   = 1;
                end
            end
            res_ready = 1'b1;
            if (res_valid && res_row_idx == 2 && dn_left > 0) begin
                res_ready = 1'b0;
                dn_left--;
                hold_cycles++;
                if (!held_set) begin
                    held_data = res_data; held_idx = res_row_idx; held_set = 1;
                end else if (res_data !== held_data || res_row_idx !== held_idx) begin
                    hold_bad = 1;
                end
            end
            if (row_in_valid && row_in_ready) rows_sent++;
            if (res_valid && res_ready) begin
                log_idx.push_back(res_row_idx);
                log_last.push_back(res_last);
                log_data.push_back(res_data);
            end
            if (frame_done) begin
                log_done++;
                busy_at_done = frame_busy;
            end
            @(negedge clk);
            frame_start = 1'b0;
            stray_done  = 1'b0;
            cyc++;
        end
        row_in_valid = 1'b0;
        repeat (4) begin
            if (frame_done) log_done++;
            @(negedge clk);
        end
        log_starts = start_cnt - s0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({frame_busy, frame_done, err_timeout, row_in_ready, eng_start, res_valid, res_last} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000", {frame_busy, frame_done, err_timeout,
                     row_in_ready, eng_start, res_valid, res_last});
        end
        n_checks++;
        if (res_row_idx !== '0) begin
            n_fail++; $display("FAIL reset_row_idx: got %0d expected 0", res_row_idx);
        end
        n_checks++;
        if (eng_row_data !== '0) begin
            n_fail++; $display("FAIL reset_eng_row_data: got %h expected 0", eng_row_data);
        end
        n_checks++;
        if (res_data !== '0) begin
            n_fail++; $display("FAIL reset_res_data: got %h expected 0", res_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (frame_busy !== 1'b0 || row_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: busy=%b ready=%b expected 0 0", frame_busy, row_in_ready);
        end
    endtask

    // Ramp rows: the [-1,2,-1] kernel on a linear ramp gives all zeros.
    task automatic test_ramp();
        run_frame(ramp_row, 0, 0, 0);
        n_checks++;
        if (log_data.size() !== NUM_ROWS) begin
            n_fail++; $display("FAIL ramp_count: got %0d results expected %0d", log_data.size(), NUM_ROWS);
        end
        for (int i = 0; i < log_data.size(); i++) begin
            n_checks++;
            if (log_idx[i] !== IDX_W'(i) || log_last[i] !== (i == NUM_ROWS - 1)) begin
                n_fail++;
                $display("FAIL ramp_idx_last[%0d]: got idx=%0d last=%b expected idx=%0d last=%b",
                         i, log_idx[i], log_last[i], i, (i == NUM_ROWS - 1));
            end
            n_checks++;
            if (log_data[i] !== '0) begin
                n_fail++; $display("FAIL ramp_data[%0d]: got %h expected 0", i, log_data[i]);
            end
        end
        n_checks++;
        if (log_done !== 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_frame_done: got pulses=%0d busy=%b expected 1 0", log_done, busy_at_done);
        end
    endtask

    // Alternating row: pixel 0 = -10, odd pixels +10, so even results are +40.
    task automatic test_alternating();
        int m0;
        m0 = moved_cnt;
        run_frame(alt_row, 0, 0, 0);
        n_checks++;
        if (log_data.size() !== NUM_ROWS) begin
            n_fail++; $display("FAIL alt_count: got %0d results expected %0d", log_data.size(), NUM_ROWS);
        end
        for (int i = 0; i < log_data.size(); i++) begin
            n_checks++;
            if (log_data[i] !== exp_alt) begin
                n_fail++; $display("FAIL alt_data[%0d]: got %h expected %h", i, log_data[i], exp_alt);
            end
        end
        n_checks++;
        if (moved_cnt - m0 !== 0) begin
            n_fail++; $display("FAIL alt_row_stable: got %0d changes expected 0", moved_cnt - m0);
        end
        n_checks++;
        if (log_starts !== NUM_ROWS) begin
            n_fail++; $display("FAIL alt_start_count: got %0d expected %0d", log_starts, NUM_ROWS);
        end
    endtask

    task automatic test_stall();
        run_frame(alt_row, 20, 15, 0);
        n_checks++;
        if (stall_start_bad !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_start: got eng_start during stall=%b expected 0", stall_start_bad);
        end
        n_checks++;
        if (hold_bad !== 1'b0 || hold_cycles !== 15) begin
            n_fail++;
            $display("FAIL stall_hold: got unstable=%b held_cycles=%0d expected 0 15", hold_bad, hold_cycles);
        end
        n_checks++;
        if (log_data.size() !== NUM_ROWS) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", log_data.size(), NUM_ROWS);
        end else if (log_idx[2] !== 2 || log_data[2] !== exp_alt) begin
            n_fail++;
            $display("FAIL stall_row2: got idx=%0d data=%h expected idx=2 data=%h", log_idx[2], log_data[2], exp_alt);
        end
        n_checks++;
        if (log_done !== 1 || log_starts !== NUM_ROWS) begin
            n_fail++;
            $display("FAIL stall_done_starts: got done=%0d starts=%0d expected 1 %0d", log_done, log_starts, NUM_ROWS);
        end
    endtask

    task automatic test_timeout();
        int   t0, t1;
        bit   saw_res, saw_done;
        logic busy_at_err;
        eng_hang = 1'b1;
        t0 = -1; t1 = -1; saw_res = 0; saw_done = 0; busy_at_err = 1'b1;
        @(negedge clk);
        frame_start = 1'b1; row_in_data = ramp_row; row_in_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (eng_start) begin
                t0 = cyc_cnt;
                break;
            end
            @(negedge clk);
        end
        row_in_valid = 1'b0;
        for (int k = 0; k < 300 && t0 >= 0; k++) begin
            @(negedge clk);
            if (res_valid) saw_res = 1;
            if (frame_done) saw_done = 1;
            if (err_timeout) begin
                t1 = cyc_cnt;
                busy_at_err = frame_busy;
                break;
            end
        end
        n_checks++;
        if (t0 < 0 || t1 - t0 !== TIMEOUT_CYCLES) begin
            n_fail++;
            $display("FAIL timeout_latency: got start@%0d err@%0d expected distance %0d", t0, t1, TIMEOUT_CYCLES);
        end
        n_checks++;
        if (busy_at_err !== 1'b0 || saw_res !== 1'b0 || saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got busy=%b res_valid_seen=%b frame_done_seen=%b expected 0 0 0",
                     busy_at_err, saw_res, saw_done);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
        end
        eng_hang = 1'b0;
        run_frame(ramp_row, 0, 0, 0);
        n_checks++;
        if (err_after_start !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: got %b expected 0", err_after_start);
        end
        n_checks++;
        if (log_done !== 1 || log_data.size() !== NUM_ROWS) begin
            n_fail++;
            $display("FAIL timeout_recovery: got done=%0d results=%0d expected 1 %0d", log_done, log_data.size(), NUM_ROWS);
        end
    endtask

    // Done arrives 127 cycles after the start pulse: the cycle the watchdog would fire.
    task automatic test_boundary();
        eng_delay = TIMEOUT_CYCLES - 1;
        run_frame(ramp_row, 0, 0, 0);
        eng_delay = 66;
        n_checks++;
        if (log_data.size() !== NUM_ROWS || log_done !== 1) begin
            n_fail++;
            $display("FAIL boundary_accept: got results=%0d done=%0d expected %0d 1", log_data.size(), log_done, NUM_ROWS);
        end
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL boundary_err: got %b expected 0", err_timeout);
        end
    endtask

    task automatic test_junk();
        run_frame(alt_row, 3, 0, 1);
        n_checks++;
        if (log_data.size() !== NUM_ROWS) begin
            n_fail++; $display("FAIL junk_count: got %0d expected %0d", log_data.size(), NUM_ROWS);
        end
        for (int i = 0; i < log_idx.size(); i++) begin
            n_checks++;
            if (log_idx[i] !== IDX_W'(i)) begin
                n_fail++; $display("FAIL junk_idx[%0d]: got %0d expected %0d", i, log_idx[i], i);
            end
        end
        n_checks++;
        if (log_done !== 1 || log_starts !== NUM_ROWS) begin
            n_fail++;
            $display("FAIL junk_done_starts: got done=%0d starts=%0d expected 1 %0d", log_done, log_starts, NUM_ROWS);
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        bit seen_start, stray_bad;
        seen_start = 0; stray_bad = 0;
        @(negedge clk);
        frame_start = 1'b1; row_in_data = alt_row; row_in_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 20 && !seen_start; k++) begin
            if (eng_start) seen_start = 1;
            else @(negedge clk);
        end
        row_in_valid = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        n_checks++;
        if (!seen_start || frame_busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_setup: got start_seen=%b busy=%b expected 1 1", seen_start, frame_busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({frame_busy, frame_done, err_timeout, row_in_ready, eng_start, res_valid, res_last} !== 7'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b expected 0000000", {frame_busy, frame_done, err_timeout,
                     row_in_ready, eng_start, res_valid, res_last});
        end
        n_checks++;
        if (eng_row_data !== '0 || res_data !== '0 || res_row_idx !== '0) begin
            n_fail++;
            $display("FAIL midrst_data: got row=%h res=%h idx=%0d expected all 0", eng_row_data, res_data, res_row_idx);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (frame_busy || res_valid || eng_start) stray_bad = 1;
        end
        n_checks++;
        if (stray_bad !== 1'b0 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL midrst_stray_done: got activity=%b late_dones=%0d expected 0 1", stray_bad, done_cnt - d0);
        end
        run_frame(ramp_row, 0, 0, 0);
        n_checks++;
        if (log_data.size() !== NUM_ROWS || log_idx[0] !== '0 || log_done !== 1) begin
            n_fail++;
            $display("FAIL midrst_restart: got results=%0d first_idx=%0d done=%0d expected %0d 0 1",
                     log_data.size(), (log_idx.size() > 0) ? log_idx[0] : '1, log_done, NUM_ROWS);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ramp_row[8*i +: 8] = 8'(i);
            alt_row[8*i +: 8]  = (i % 2 == 0) ? 8'(-10) : 8'(10);
        end
        for (int i = 0; i < 30; i++) begin
            exp_alt[18*i +: 18] = (i % 2 == 0) ? 18'(40) : 18'(-40);
        end
        rst          = 1'b1;
        frame_start  = 1'b0;
        row_in_valid = 1'b0;
        row_in_data  = '0;
        res_ready    = 1'b0;
        stray_done   = 1'b0;

        test_reset();
        test_ramp();
        test_alternating();
        test_stall();
        test_timeout();
        test_boundary();
        test_junk();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
